// File: rtl/apb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// apb_bridge_pkg
// Shared definitions for the AHB2APB bridge:
//   - default address/data widths
//   - APB controller state encoding
//   - base/limit constants of the three APB slave regions
//   - decodeSel(): maps an address to a one-hot 3-bit slave select
// No ports (package).
// -----------------------------------------------------------------------------
package apb_bridge_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } apb_state_e;

    localparam logic [31:0] REGION0_BASE  = 32'h8000_0000;
    localparam logic [31:0] REGION0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] REGION1_BASE  = 32'h8400_0000;
    localparam logic [31:0] REGION1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] REGION2_BASE  = 32'h8800_0000;
    localparam logic [31:0] REGION2_LIMIT = 32'h8BFF_FFFF;

    // Addresses outside all three regions select no slave; the transfer
    // still runs through SETUP/ACCESS with pselx = 0.
    function automatic logic [2:0] decodeSel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if (addr >= REGION0_BASE && addr <= REGION0_LIMIT) begin
            sel = 3'b001;
        end else if (addr >= REGION1_BASE && addr <= REGION1_LIMIT) begin
            sel = 3'b010;
        end else if (addr >= REGION2_BASE && addr <= REGION2_LIMIT) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_controller.sv
// -----------------------------------------------------------------------------
// apb_controller
// APB side of the AHB2APB bridge. Takes the qualified transfer (valid) and the
// pipelined AHB address/data/direction from the AHB slave interface, runs the
// APB SETUP -> ACCESS sequence and stalls the AHB master through hready_out
// while an APB transfer is in flight. All outputs are registered.
//
// Ports:
//   hclk, hreset          clock, synchronous active-high reset
//   valid                 qualified AHB transfer
//   hwrite, hwrite_reg    current / 1-cycle delayed AHB direction
//   haddr, haddr1, haddr2 current / 1-cycle / 2-cycle delayed AHB address
//   hwdata, hwdata1       current / 1-cycle delayed AHB write data
//   pready                (only with APB_PREADY_EN) APB slave ready
//   pwrite, penable, pselx, paddr, pwdata   APB master signals
//   hready_out            0 stalls the AHB master
//
// Configuration macro: APB_PREADY_EN
//   undefined: ACCESS always lasts one cycle, no pready port.
//   defined:   ACCESS is extended while pready = 0, with hready_out held low.
// -----------------------------------------------------------------------------
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
`ifdef APB_PREADY_EN
    input  logic              pready,
`endif
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata1,
    output logic              pwrite,
    output logic              penable,
    output logic [2:0]        pselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hready_out
);

    apb_state_e        state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic              penable_q, penable_d;
    logic [2:0]        pselx_q, pselx_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hready_q, hready_d;

    logic accessDone;
    logic enableHready;

`ifdef APB_PREADY_EN
    assign accessDone   = pready;
    assign enableHready = 1'b0;
`else
    assign accessDone   = 1'b1;
    assign enableHready = 1'b1;
`endif

    // Next state is chosen first; the output loads then depend on the state
    // being entered (and, for WRITE/WRITEP, on where we came from, since a
    // write pipelined behind WENABLEP has its address two cycles back).
    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        pselx_d   = pselx_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;

        case (state_q)
            ST_IDLE: begin
                if (valid && !hwrite)     state_d = ST_READ;
                else if (valid && hwrite) state_d = ST_WWAIT;
            end
            ST_WWAIT:   state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:    state_d = ST_RENABLE;
            ST_WRITE:   state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:  state_d = ST_WENABLEP;
            ST_RENABLE, ST_WENABLE: begin
                if (accessDone) begin
                    if (valid && !hwrite)     state_d = ST_READ;
                    else if (valid && hwrite) state_d = ST_WWAIT;
                    else                      state_d = ST_IDLE;
                end
            end
            ST_WENABLEP: begin
                if (accessDone) begin
                    if (!hwrite_reg) state_d = ST_READ;
                    else if (valid)  state_d = ST_WRITEP;
                    else             state_d = ST_WRITE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_READ: begin
                paddr_d   = haddr;
                pwrite_d  = 1'b0;
                pselx_d   = decodeSel(32'(haddr));
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = haddr2;
                    pwdata_d = hwdata1;
                    pselx_d  = decodeSel(32'(haddr2));
                end else begin
                    paddr_d  = haddr1;
                    pwdata_d = hwdata;
                    pselx_d  = decodeSel(32'(haddr1));
                end
                pwrite_d  = 1'b1;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_d = 1'b1;
                hready_d  = enableHready;
            end
            default: begin
                pselx_d   = 3'b000;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        endcase
    end

    // State and all output registers; reset wins even mid-transfer.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pselx_q   <= 3'b000;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    assign pwrite     = pwrite_q;
    assign penable    = penable_q;
    assign pselx      = pselx_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign hready_out = hready_q;

endmodule

// File: tb/tb_apb_controller.sv
// -----------------------------------------------------------------------------
// tb_apb_controller
// Directed bench for apb_controller. The stimulus process drives one cycle of
// AHB-side inputs at a time and queues the hand-computed APB outputs expected
// after that edge; an independent monitor pops and compares on every falling
// edge. The upstream delay registers (haddr1/haddr2/hwdata1/hwrite_reg) are
// modelled here as plain pipeline flops of the driven AHB signals.
// Snapshot packing: {pwrite, penable, pselx, paddr, pwdata, hready_out}.
// -----------------------------------------------------------------------------
module tb_apb_controller;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        valid = 1'b0;
    logic        hwrite = 1'b0;
    logic        hwrite_reg = 1'b0;
    logic [31:0] haddr = '0;
    logic [31:0] haddr1 = '0;
    logic [31:0] haddr2 = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] hwdata1 = '0;
    logic        pwrite;
    logic        penable;
    logic [2:0]  pselx;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hready_out;
`ifdef APB_PREADY_EN
    logic        pready = 1'b1;
`endif

    typedef logic [69:0] snap_t;

    snap_t expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    failures = 0;

    apb_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .valid      (valid),
`ifdef APB_PREADY_EN
        .pready     (pready),
`endif
        .hwrite     (hwrite),
        .hwrite_reg (hwrite_reg),
        .haddr      (haddr),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .hwdata     (hwdata),
        .hwdata1    (hwdata1),
        .pwrite     (pwrite),
        .penable    (penable),
        .pselx      (pselx),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .hready_out (hready_out)
    );

    // Free-running bridge clock
    always #5 hclk = ~hclk;

    // Upstream AHB slave interface delay registers
    always @(posedge hclk) begin
        haddr1     <= haddr;
        haddr2     <= haddr1;
        hwdata1    <= hwdata;
        hwrite_reg <= hwrite;
    end

    function automatic snap_t snap(input logic pw, input logic pe, input logic [2:0] ps,
                                   input logic [31:0] pa, input logic [31:0] pd, input logic hr);
        return {pw, pe, ps, pa, pd, hr};
    endfunction

    task automatic checkOutput(input string nm, input snap_t exp);
        snap_t act;
        act = {pwrite, penable, pselx, paddr, pwdata, hready_out};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got pwrite=%b penable=%b pselx=%b paddr=%h pwdata=%h hready=%b, expected pwrite=%b penable=%b pselx=%b paddr=%h pwdata=%h hready=%b",
                     nm, act[69], act[68], act[67:65], act[64:33], act[32:1], act[0],
                     exp[69], exp[68], exp[67:65], exp[64:33], exp[32:1], exp[0]);
        end
    endtask

    // Monitor: one expected snapshot is consumed per falling edge
    always @(negedge hclk) begin
        if (expQ.size() > 0) begin
            checkOutput(nameQ.pop_front(), expQ.pop_front());
        end
    end

    task automatic applyStimulus(input string nm, input logic rst, input logic v, input logic w,
                                 input logic [31:0] a, input logic [31:0] d, input snap_t exp);
        hreset = rst;
        valid  = v;
        hwrite = w;
        haddr  = a;
        hwdata = d;
        @(posedge hclk);
        expQ.push_back(exp);
        nameQ.push_back(nm);
        #1;
    endtask

    initial begin
        $display("[TB] apb_controller directed test start");

        // Reset
        applyStimulus("reset0", 1, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h0, 32'h0, 1));
        applyStimulus("reset1", 1, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h0, 32'h0, 1));

        // Single read
        applyStimulus("rd_setup",  0, 1, 0, 32'h8000_0010, 32'h0, snap(0, 0, 3'b001, 32'h8000_0010, 32'h0, 0));
        applyStimulus("rd_access", 0, 0, 0, 32'h0, 32'h0, snap(0, 1, 3'b001, 32'h8000_0010, 32'h0, 1));
        applyStimulus("rd_idle",   0, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h8000_0010, 32'h0, 1));
        applyStimulus("idle_hold", 0, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h8000_0010, 32'h0, 1));

        // Single write
        applyStimulus("wr_wwait",  0, 1, 1, 32'h8400_0004, 32'h0, snap(0, 0, 3'b000, 32'h8000_0010, 32'h0, 1));
        applyStimulus("wr_setup",  0, 0, 0, 32'h0, 32'hDEAD_BEEF, snap(1, 0, 3'b010, 32'h8400_0004, 32'hDEAD_BEEF, 0));
        applyStimulus("wr_access", 0, 0, 0, 32'h0, 32'h0, snap(1, 1, 3'b010, 32'h8400_0004, 32'hDEAD_BEEF, 1));
        applyStimulus("wr_idle",   0, 0, 0, 32'h0, 32'h0, snap(1, 0, 3'b000, 32'h8400_0004, 32'hDEAD_BEEF, 1));

        // Back-to-back writes: WWAIT -> WRITEP -> WENABLEP -> WRITE -> WENABLE
        applyStimulus("b2b_wwait",    0, 1, 1, 32'h8800_0000, 32'h0, snap(1, 0, 3'b000, 32'h8400_0004, 32'hDEAD_BEEF, 1));
        applyStimulus("b2b_writep",   0, 1, 1, 32'h8800_0004, 32'h1111_1111, snap(1, 0, 3'b100, 32'h8800_0000, 32'h1111_1111, 0));
        applyStimulus("b2b_wenablep", 0, 0, 1, 32'h8800_0004, 32'h2222_2222, snap(1, 1, 3'b100, 32'h8800_0000, 32'h1111_1111, 1));
        applyStimulus("b2b_write2",   0, 0, 0, 32'h0, 32'h0, snap(1, 0, 3'b100, 32'h8800_0004, 32'h2222_2222, 0));
        applyStimulus("b2b_wenable2", 0, 0, 0, 32'h0, 32'h0, snap(1, 1, 3'b100, 32'h8800_0004, 32'h2222_2222, 1));

        // Out-of-range read straight after WENABLE (no IDLE in between)
        applyStimulus("oor_setup",  0, 1, 0, 32'h9000_0000, 32'h0, snap(0, 0, 3'b000, 32'h9000_0000, 32'h2222_2222, 0));
        applyStimulus("oor_access", 0, 0, 0, 32'h0, 32'h0, snap(0, 1, 3'b000, 32'h9000_0000, 32'h2222_2222, 1));
        applyStimulus("oor_idle",   0, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h9000_0000, 32'h2222_2222, 1));

        // Decode boundaries with chained reads (RENABLE -> READ)
        applyStimulus("top_r2_setup",  0, 1, 0, 32'h8BFF_FFFF, 32'h0, snap(0, 0, 3'b100, 32'h8BFF_FFFF, 32'h2222_2222, 0));
        applyStimulus("top_r2_access", 0, 1, 0, 32'h8C00_0000, 32'h0, snap(0, 1, 3'b100, 32'h8BFF_FFFF, 32'h2222_2222, 1));
        applyStimulus("above_setup",   0, 1, 0, 32'h8C00_0000, 32'h0, snap(0, 0, 3'b000, 32'h8C00_0000, 32'h2222_2222, 0));
        applyStimulus("above_access",  0, 1, 0, 32'h83FF_FFFF, 32'h0, snap(0, 1, 3'b000, 32'h8C00_0000, 32'h2222_2222, 1));
        applyStimulus("top_r0_setup",  0, 1, 0, 32'h83FF_FFFF, 32'h0, snap(0, 0, 3'b001, 32'h83FF_FFFF, 32'h2222_2222, 0));
        applyStimulus("top_r0_access", 0, 0, 0, 32'h0, 32'h0, snap(0, 1, 3'b001, 32'h83FF_FFFF, 32'h2222_2222, 1));
        applyStimulus("top_r0_idle",   0, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h83FF_FFFF, 32'h2222_2222, 1));

        // Reset in the middle of a write
        applyStimulus("rst_wwait", 0, 1, 1, 32'h8000_0020, 32'h0, snap(0, 0, 3'b000, 32'h83FF_FFFF, 32'h2222_2222, 1));
        applyStimulus("rst_setup", 0, 0, 0, 32'h0, 32'h3333_3333, snap(1, 0, 3'b001, 32'h8000_0020, 32'h3333_3333, 0));
        applyStimulus("rst_abort", 1, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h0, 32'h0, 1));
        applyStimulus("rst_idle0", 0, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h0, 32'h0, 1));
        applyStimulus("rst_idle1", 0, 0, 0, 32'h0, 32'h0, snap(0, 0, 3'b000, 32'h0, 32'h0, 1));

        // Let the monitor consume the last queued expectation
        @(negedge hclk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
